// File: rtl/mem_access_unit.sv
// mem_access_unit: single-outstanding load/store unit between execute and a wait-state data memory port.
// Latency: accept, one or more beat cycles (until mem_ack or TIMEOUT), then a 1-cycle resp_valid; illegal/misaligned skip the beats.
// Backpressure: req_ready only in IDLE, no resp backpressure. MEM_ACCESS_SPLIT_EN enables two-beat misaligned accesses.
module mem_access_unit #(
    parameter int XLEN    = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              resp_valid,
    output logic [XLEN-1:0]   resp_rdata,
    output logic [1:0]        resp_err,
    output logic              mem_read,
    output logic [XLEN/8-1:0] mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_in,
    input  logic [XLEN-1:0]   mem_out,
    input  logic              mem_ack
);
`ifdef MEM_ACCESS_SPLIT_EN
    localparam int WIDE = 2;
`else
    localparam int WIDE = 1;
`endif
    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);
    localparam int MW   = WIDE * NB;
    localparam int DW   = WIDE * XLEN;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BEAT1 = 2'd1;
`ifdef MEM_ACCESS_SPLIT_EN
    localparam logic [1:0] S_BEAT2 = 2'd2;
`endif
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic [1:0] ERR_OK  = 2'b00;
    localparam logic [1:0] ERR_TMO = 2'b10;
    localparam logic [1:0] ERR_ILL = 2'b11;
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    logic [1:0]        state_q, state_d;
    logic              we_q, we_d;
    logic [2:0]        f3_q, f3_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [1:0]        err_q, err_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [DW-1:0]     rbuf_q, rbuf_d;

    logic              req_ill;
    logic [OFFW-1:0]   off;
    logic [ADDR_W-1:0] base;
    logic [MW-1:0]     smask, wmask;
    logic [DW-1:0]     wshift;
    logic [XLEN-1:0]   rlow, lmask, ext;
    logic              sbit;
    logic              tmo;

    always_comb begin
        req_ill = (req_we && req_funct3[2]) || (req_funct3 == 3'b111) ||
                  ((XLEN == 32) && (req_funct3 == 3'b011 || req_funct3 == 3'b110));
    end

`ifndef MEM_ACCESS_SPLIT_EN
    logic req_mis;
    always_comb begin
        case (req_funct3[1:0])
            2'd1:    req_mis = req_addr[0];
            2'd2:    req_mis = |req_addr[1:0];
            2'd3:    req_mis = |req_addr[2:0];
            default: req_mis = 1'b0;
        endcase
    end
`endif

    // Masks and data are built double-width so a split access's second beat is simply the upper half.
    always_comb begin
        off  = addr_q[OFFW-1:0];
        base = {addr_q[ADDR_W-1:OFFW], {OFFW{1'b0}}};
        case (f3_q[1:0])
            2'd0:    smask = MW'(8'h01);
            2'd1:    smask = MW'(8'h03);
            2'd2:    smask = MW'(8'h0F);
            default: smask = MW'(8'hFF);
        endcase
        wmask  = smask << off;
        wshift = DW'(wdata_q) << {off, 3'b000};
        tmo    = (cnt_q == TMO_LAST);
    end

    always_comb begin
        rlow = XLEN'(rbuf_q >> {off, 3'b000});
        case (f3_q[1:0])
            2'd0: begin
                lmask = XLEN'(8'hFF);
                sbit  = rlow[7];
            end
            2'd1: begin
                lmask = XLEN'(16'hFFFF);
                sbit  = rlow[15];
            end
            2'd2: begin
                lmask = XLEN'(32'hFFFF_FFFF);
                sbit  = rlow[31];
            end
            default: begin
                lmask = '1;
                sbit  = 1'b0;
            end
        endcase
        ext = (rlow & lmask) | ((!f3_q[2] && sbit) ? ~lmask : '0);
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        rbuf_d  = rbuf_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    f3_d    = req_funct3;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    err_d   = ERR_OK;
                    cnt_d   = '0;
                    rbuf_d  = '0;
                    if (req_ill) begin
                        state_d = S_RESP;
                        err_d   = ERR_ILL;
                    end
`ifdef MEM_ACCESS_SPLIT_EN
                    else begin
                        state_d = S_BEAT1;
                    end
`else
                    else if (req_mis) begin
                        state_d = S_RESP;
                        err_d   = 2'b01;
                    end else begin
                        state_d = S_BEAT1;
                    end
`endif
                end
            end
            S_BEAT1: begin
                if (mem_ack) begin
                    rbuf_d[XLEN-1:0] = mem_out;
                    cnt_d            = '0;
`ifdef MEM_ACCESS_SPLIT_EN
                    state_d = (|wmask[MW-1:NB]) ? S_BEAT2 : S_RESP;
`else
                    state_d = S_RESP;
`endif
                end else if (tmo) begin
                    state_d = S_RESP;
                    err_d   = ERR_TMO;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
`ifdef MEM_ACCESS_SPLIT_EN
            S_BEAT2: begin
                if (mem_ack) begin
                    rbuf_d[DW-1:XLEN] = mem_out;
                    state_d           = S_RESP;
                end else if (tmo) begin
                    state_d = S_RESP;
                    err_d   = ERR_TMO;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
`endif
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= ERR_OK;
            cnt_q   <= '0;
            rbuf_q  <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            rbuf_q  <= rbuf_d;
        end
    end

    always_comb begin
        mem_read  = 1'b0;
        mem_write = '0;
        mem_addr  = '0;
        mem_in    = '0;
        case (state_q)
            S_BEAT1: begin
                mem_addr = base;
                mem_read = !we_q;
                if (we_q) begin
                    mem_write = wmask[NB-1:0];
                    mem_in    = wshift[XLEN-1:0];
                end
            end
`ifdef MEM_ACCESS_SPLIT_EN
            S_BEAT2: begin
                mem_addr = base + ADDR_W'(NB);
                mem_read = !we_q;
                if (we_q) begin
                    mem_write = wmask[MW-1:NB];
                    mem_in    = wshift[DW-1:XLEN];
                end
            end
`endif
            default: ;
        endcase
    end

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = (state_q == S_RESP);
    assign resp_err   = resp_valid ? err_q : ERR_OK;
    assign resp_rdata = (resp_valid && !we_q && err_q == ERR_OK) ? ext : '0;

endmodule
